// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences one C = A x B on the systolic MAC grid.
//   Operand bytes arrive on a valid/ready stream (A row-major, then B
//   row-major) and are buffered. The grid edges are then driven with a
//   skewed wavefront. After the pipeline drains, C is unloaded row-major
//   on a valid/yumi stream.
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   flush_i               synchronous abort back to LOAD
//   valid_i/data_i        operand stream in, ready_o accepts
//   a_o/a_valid_o         row-edge operands, one lane per grid row
//   b_o/b_valid_o         column-edge operands, one lane per grid column
//   clear_o, mac_en_o     grid accumulator clear pulse, grid advance enable
//   c_i                   grid results, element (i,j) at lane i*W+j
//   valid_o/data_o/yumi_i result stream out
//   busy_o                high whenever the sequencer is not in LOAD
module matmul_sequencer #(
    parameter int width_p        = 8,
    parameter int array_height_p = 2,
    parameter int array_width_p  = 2,
    parameter int depth_k_p      = 2,
    parameter int mac_latency_p  = 1
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic                                              flush_i,
    input  logic                                              valid_i,
    input  logic [width_p-1:0]                                data_i,
    output logic                                              ready_o,
    output logic [array_height_p*width_p-1:0]                 a_o,
    output logic [array_height_p-1:0]                         a_valid_o,
    output logic [array_width_p*width_p-1:0]                  b_o,
    output logic [array_width_p-1:0]                          b_valid_o,
    output logic                                              clear_o,
    output logic                                              mac_en_o,
    input  logic [array_height_p*array_width_p*width_p-1:0]   c_i,
    output logic                                              valid_o,
    output logic [width_p-1:0]                                data_o,
    input  logic                                              yumi_i,
    output logic                                              busy_o
);

    localparam int H     = array_height_p;
    localparam int W     = array_width_p;
    localparam int K     = depth_k_p;
    localparam int N_A   = H * K;
    localparam int N     = N_A + K * W;
    localparam int FL    = K + H + W - 2;
    localparam int NC    = H * W;
    localparam int M1    = (N > FL) ? N : FL;
    localparam int M2    = (M1 > NC) ? M1 : NC;
    localparam int CMAX  = (M2 > mac_latency_p) ? M2 : mac_latency_p;
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    // One counter serves every phase: load slot, feed step t, drain cycle, unload index u.
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_n;
    logic               w_load_beat;
    logic [width_p-1:0] r_buf [N];

    logic                       r_ready, r_clear, r_mac_en, r_valid, r_busy;
    logic [H*width_p-1:0]       r_a, w_a_n;
    logic [H-1:0]               r_av, w_av_n;
    logic [W*width_p-1:0]       r_b, w_b_n;
    logic [W-1:0]               r_bv, w_bv_n;
    logic [width_p-1:0]         r_data, w_data_n;

    // Next-state and counter logic; flush_i overrides every transition.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_load_beat = 1'b0;
        if (flush_i) begin
            w_state_n = S_LOAD;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (valid_i) begin
                        w_load_beat = 1'b1;
                        if (r_cnt == CNT_W'(N - 1)) begin
                            w_state_n = S_CLEAR;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_n = r_cnt;
                    end
                end
                S_CLEAR: begin
                    w_state_n = S_FEED;
                    w_cnt_n   = '0;
                end
                S_FEED: begin
                    if (r_cnt == CNT_W'(FL - 1)) begin
                        w_state_n = S_DRAIN;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(mac_latency_p - 1)) begin
                        w_state_n = S_UNLOAD;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
                S_UNLOAD: begin
                    if (yumi_i) begin
                        if (r_cnt == CNT_W'(NC - 1)) begin
                            w_state_n = S_LOAD;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_n = r_cnt;
                    end
                end
                default: begin
                    w_state_n = S_LOAD;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs, derived from the upcoming state and counter
    // so every output lines up with the state it belongs to.
    always_comb begin
        w_a_n    = '0;
        w_av_n   = '0;
        w_b_n    = '0;
        w_bv_n   = '0;
        w_data_n = '0;
        if (w_state_n == S_FEED) begin
            // Row i carries A[i][k] at step t = i + k; column j carries B[k][j] at t = k + j.
            for (int i = 0; i < H; i++) begin
                for (int k = 0; k < K; k++) begin
                    if (w_cnt_n == CNT_W'(i + k)) begin
                        w_a_n[i*width_p +: width_p] = r_buf[i*K + k];
                        w_av_n[i]                   = 1'b1;
                    end else begin
                        w_av_n[i] = w_av_n[i];
                    end
                end
            end
            for (int j = 0; j < W; j++) begin
                for (int k = 0; k < K; k++) begin
                    if (w_cnt_n == CNT_W'(k + j)) begin
                        w_b_n[j*width_p +: width_p] = r_buf[N_A + k*W + j];
                        w_bv_n[j]                   = 1'b1;
                    end else begin
                        w_bv_n[j] = w_bv_n[j];
                    end
                end
            end
        end else if (w_state_n == S_UNLOAD) begin
            for (int e = 0; e < NC; e++) begin
                if (w_cnt_n == CNT_W'(e)) begin
                    w_data_n = c_i[e*width_p +: width_p];
                end else begin
                    w_data_n = w_data_n;
                end
            end
        end else begin
            w_data_n = '0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_clear  <= 1'b0;
            r_mac_en <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_a      <= '0;
            r_av     <= '0;
            r_b      <= '0;
            r_bv     <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_ready  <= (w_state_n == S_LOAD);
            r_clear  <= (w_state_n == S_CLEAR);
            r_mac_en <= (w_state_n == S_FEED) || (w_state_n == S_DRAIN);
            r_valid  <= (w_state_n == S_UNLOAD);
            r_busy   <= (w_state_n != S_LOAD);
            r_a      <= w_a_n;
            r_av     <= w_av_n;
            r_b      <= w_b_n;
            r_bv     <= w_bv_n;
            r_data   <= w_data_n;
        end
    end

    // Operand buffer; contents need no reset because every run rewrites all slots.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < N; s++) begin
            if (w_load_beat && (r_cnt == CNT_W'(s))) begin
                r_buf[s] <= data_i;
            end
        end
    end

    assign ready_o   = r_ready;
    assign clear_o   = r_clear;
    assign mac_en_o  = r_mac_en;
    assign valid_o   = r_valid;
    assign busy_o    = r_busy;
    assign a_o       = r_a;
    assign a_valid_o = r_av;
    assign b_o       = r_b;
    assign b_valid_o = r_bv;
    assign data_o    = r_data;

endmodule
